// File: rtl/noc_router_pkg.sv
// Shared router definitions: port index encoding, allocator state type and
// a small wrap-around increment helper used by the round-robin pointer.
package noc_router_pkg;

  localparam int unsigned NUM_PORTS  = 5;
  localparam int unsigned PORT_IDX_W = 3;

  // Port indices double as the crossbar mux select encoding.
  localparam logic [PORT_IDX_W-1:0] PORT_N = 3'd0;
  localparam logic [PORT_IDX_W-1:0] PORT_S = 3'd1;
  localparam logic [PORT_IDX_W-1:0] PORT_W = 3'd2;
  localparam logic [PORT_IDX_W-1:0] PORT_E = 3'd3;
  localparam logic [PORT_IDX_W-1:0] PORT_L = 3'd4;

  typedef enum logic {IDLE, LOCKED} alloc_state_t;

  // (idx + 1) mod n for a port index.
  function automatic logic [PORT_IDX_W-1:0] wrap_inc(input logic [PORT_IDX_W-1:0] idx,
                                                     input int unsigned n);
    if (32'(idx) >= n - 1) begin
      return '0;
    end
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: the first set request found when
// scanning upward from ptr_i (wrapping) wins.
module rr_pick
  import noc_router_pkg::*;
#(
  parameter int unsigned NUM_IN = NUM_PORTS
) (
  input  logic [NUM_IN-1:0]     req_i,
  input  logic [PORT_IDX_W-1:0] ptr_i,
  output logic [NUM_IN-1:0]     gnt_o,
  output logic [PORT_IDX_W-1:0] idx_o,
  output logic                  any_o
);

  // Scan candidates in rotated order; first hit wins.
  always_comb begin
    int unsigned cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      cand = (32'(ptr_i) + i) % NUM_IN;
      if (!any_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = PORT_IDX_W'(cand);
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wormhole_output_allocator.sv
// Per-output wormhole switch allocator: round-robin arbitration in IDLE,
// then the output stays locked to the winner until its tail flit is granted.
// Every flit transfer is gated on the downstream credit.
// Optional watchdog: define ALLOC_TIMEOUT_EN to release a lock that sees no
// grant for TIMEOUT cycles (err_o pulses on that release).
module wormhole_output_allocator
  import noc_router_pkg::*;
#(
  parameter int unsigned NUM_IN  = NUM_PORTS,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req_i,
  input  logic [NUM_IN-1:0] tail_i,
  input  logic              credit_i,
  output logic [NUM_IN-1:0] grant_o,
  output logic [2:0]        sel_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              err_o
);

  alloc_state_t          state_q;
  logic [PORT_IDX_W-1:0] owner_q;
  logic [PORT_IDX_W-1:0] rr_ptr_q;

  logic [NUM_IN-1:0]     pick_onehot_unused;
  logic [PORT_IDX_W-1:0] pick_idx;
  logic                  pick_any;

  rr_pick #(
    .NUM_IN(NUM_IN)
  ) u_rr_pick (
    .req_i(req_i),
    .ptr_i(rr_ptr_q),
    .gnt_o(pick_onehot_unused),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  // Grant only the owner, and only when it has a flit and credit exists.
  always_comb begin
    grant_o = '0;
    if (state_q == LOCKED) begin
      grant_o[owner_q] = req_i[owner_q] & credit_i;
    end
  end

  assign valid_o = |grant_o;
  assign busy_o  = (state_q == LOCKED);
  // Owner register keeps its value in IDLE, so the select holds the last owner.
  assign sel_o   = owner_q;

`ifdef ALLOC_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] wd_q;
  logic           err_q;

  assign err_o = err_q;

  // Allocator FSM with watchdog: lock on arbitration, release on tail grant or timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (pick_any) begin
            owner_q  <= pick_idx;
            rr_ptr_q <= wrap_inc(pick_idx, NUM_IN);
            state_q  <= LOCKED;
          end
        end
        LOCKED: begin
          if (valid_o) begin
            wd_q <= '0;
            if (tail_i[owner_q]) begin
              state_q <= IDLE;
            end
          end else if (wd_q == WdW'(TIMEOUT - 1)) begin
            // Stalled packet: drop the lock, rr_ptr stays as set at lock time.
            wd_q    <= '0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  logic unused_timeout;

  assign err_o          = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);

  // Allocator FSM: lock on arbitration, release only on a granted tail flit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            owner_q  <= pick_idx;
            rr_ptr_q <= wrap_inc(pick_idx, NUM_IN);
            state_q  <= LOCKED;
          end
        end
        LOCKED: begin
          if (valid_o && tail_i[owner_q]) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_wormhole_output_allocator.sv
// Self-checking bench for wormhole_output_allocator (default build).
// Expected grant owners are queued as stimulus is driven; a negedge monitor
// pops one entry per granted flit. Scenario tasks add inline cycle checks.
module tb_wormhole_output_allocator;
  import noc_router_pkg::*;

  logic       clk;
  logic       reset;
  logic [4:0] req;
  logic [4:0] tail;
  logic       credit;
  logic [4:0] grant;
  logic [2:0] sel;
  logic       valid;
  logic       busy;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] exp_q[$];
  logic [2:0] sb_exp;

  wormhole_output_allocator #(
    .NUM_IN (5),
    .TIMEOUT(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req),
    .tail_i  (tail),
    .credit_i(credit),
    .grant_o (grant),
    .sel_o   (sel),
    .valid_o (valid),
    .busy_o  (busy),
    .err_o   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor: every granted flit must match the next queued owner.
  always @(negedge clk) begin
    if (reset && valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: grant=%b sel=%0d, nothing expected", grant, sel);
      end else begin
        sb_exp = exp_q.pop_front();
        n_cmp++;
        if (grant !== (5'b00001 << sb_exp)) begin
          n_bad++;
          $display("FAIL sb_grant: got %b want %b", grant, 5'b00001 << sb_exp);
        end
        n_cmp++;
        if (sel !== sb_exp) begin
          n_bad++;
          $display("FAIL sb_sel: got %0d want %0d", sel, sb_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not finish, got timeout want finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset  = 1'b0;
    req    = '0;
    tail   = '0;
    credit = 1'b1;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (grant !== 5'b0) begin n_bad++; $display("FAIL rst_grant: got %b want 00000", grant); end
    n_cmp++; if (sel !== 3'd0) begin n_bad++; $display("FAIL rst_sel: got %0d want 0", sel); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_single();
    req = 5'b00100; tail = 5'b00100; credit = 1'b1;
    exp_q.push_back(PORT_W);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || valid !== 1'b0) begin
      n_bad++; $display("FAIL single_arb: got busy=%b valid=%b want 0 0", busy, valid);
    end
    tick();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    n_cmp++; if (grant !== 5'b00100) begin n_bad++; $display("FAIL single_grant: got %b want 00100", grant); end
    n_cmp++; if (sel !== PORT_W) begin n_bad++; $display("FAIL single_sel: got %0d want 2", sel); end
    tick();
    req = '0; tail = '0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || valid !== 1'b0) begin
      n_bad++; $display("FAIL single_idle: got busy=%b valid=%b want 0 0", busy, valid);
    end
    n_cmp++; if (sel !== PORT_W) begin n_bad++; $display("FAIL single_sel_hold: got %0d want 2", sel); end
    tick();
  endtask

  task automatic test_round_robin();
    logic exp_v;
    apply_reset();
    req = 5'b11111; tail = 5'b11111; credit = 1'b1;
    exp_q.push_back(PORT_N); exp_q.push_back(PORT_S); exp_q.push_back(PORT_W);
    exp_q.push_back(PORT_E); exp_q.push_back(PORT_L); exp_q.push_back(PORT_N);
    for (int k = 0; k < 12; k++) begin
      exp_v = (k % 2 == 1);
      @(negedge clk);
      n_cmp++; if (valid !== exp_v || busy !== exp_v) begin
        n_bad++;
        $display("FAIL rr_cycle%0d: got valid=%b busy=%b want %b %b", k, valid, busy, exp_v, exp_v);
      end
      tick();
    end
    req = '0; tail = '0;
    tick();
  endtask

  task automatic test_wormhole_hold();
    apply_reset();
    req = 5'b00010; tail = 5'b00000; credit = 1'b1;
    for (int f = 0; f < 4; f++) exp_q.push_back(PORT_S);
    tick();
    req = 5'b10010;
    tick();
    tick();
    req = 5'b10000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (valid !== 1'b0 || busy !== 1'b1 || grant[4] !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_gap%0d: got valid=%b busy=%b grant=%b want 0 1 00000",
                 k, valid, busy, grant);
      end
      tick();
    end
    req = 5'b10010;
    tick();
    tail = 5'b00010;
    @(negedge clk);
    n_cmp++; if (grant !== 5'b00010) begin n_bad++; $display("FAIL hold_tail: got %b want 00010", grant); end
    tick();
    req = 5'b10000; tail = 5'b10000;
    exp_q.push_back(PORT_L);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || valid !== 1'b0) begin
      n_bad++; $display("FAIL hold_bubble: got busy=%b valid=%b want 0 0", busy, valid);
    end
    tick();
    @(negedge clk);
    n_cmp++; if (sel !== PORT_L) begin n_bad++; $display("FAIL hold_next_sel: got %0d want 4", sel); end
    tick();
    req = '0; tail = '0;
    tick();
  endtask

  task automatic test_credit_stall();
    apply_reset();
    req = 5'b00001; tail = '0; credit = 1'b1;
    exp_q.push_back(PORT_N);
    tick();
    tick();
    credit = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (grant !== 5'b0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL stall%0d: got grant=%b busy=%b want 00000 1", k, grant, busy);
      end
      tick();
    end
    credit = 1'b1; tail = 5'b00001;
    exp_q.push_back(PORT_N);
    @(negedge clk);
    n_cmp++; if (grant !== 5'b00001) begin n_bad++; $display("FAIL stall_resume: got %b want 00001", grant); end
    tick();
    req = '0; tail = '0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_release: got %b want 0", busy); end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    req = 5'b01000; tail = '0; credit = 1'b1;
    exp_q.push_back(PORT_E); exp_q.push_back(PORT_E);
    tick();
    tick();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (grant !== 5'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midrst_ctrl: got grant=%b valid=%b busy=%b want 00000 0 0",
                        grant, valid, busy);
    end
    n_cmp++; if (sel !== 3'd0 || err !== 1'b0) begin
      n_bad++; $display("FAIL midrst_sel: got sel=%0d err=%b want 0 0", sel, err);
    end
    tick();
    reset = 1'b1;
    // rr_ptr back at 0 selects S; a stale pointer (4) would select L.
    req = 5'b10010; tail = 5'b10010;
    exp_q.push_back(PORT_S);
    tick();
    @(negedge clk);
    n_cmp++; if (sel !== PORT_S) begin n_bad++; $display("FAIL midrst_rearb: got %0d want 1", sel); end
    tick();
    req = '0; tail = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    pat = 8'b0101_1110;
    req = 5'b00100; tail = '0; credit = 1'b1;
    for (int f = 0; f < 3; f++) exp_q.push_back(PORT_W);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        tail = 5'b00100;
        exp_q.push_back(PORT_W);
      end
      if (k == 5) exp_q.push_back(PORT_W);
      if (k == 7) begin
        req = '0; tail = '0;
      end
      @(negedge clk);
      n_cmp++; if (valid !== pat[k]) begin
        n_bad++; $display("FAIL b2b_cycle%0d: got valid=%b want %b", k, valid, pat[k]);
      end
      tick();
    end
  endtask

  initial begin
    reset  = 1'b0;
    req    = '0;
    tail   = '0;
    credit = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_wormhole_hold();
    test_credit_stall();
    test_reset_mid_packet();
    test_back_to_back();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d grants outstanding want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
